// File: rtl/decode_hazard_ctrl.sv
// Decode-to-execute issue controller: RAW hazard stall, flush blocking, back-pressure.
// Optional macro DECODE_FWD_EN: oldest-slot matches forward instead of stalling.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_RUN  | normal issue, hazards and back-pressure gate decode
// ST_FLUSH| decode blocked for FLUSH_CYC cycles after a flush
module decode_hazard_ctrl #(
  parameter int WB_DEPTH  = 3,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_we,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             dec_ready,
  output logic             iss_valid,
  output logic [4:0]       iss_rd,
  output logic             iss_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             fwd_a,
  output logic             fwd_b
);

  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t              state, state_nxt;
  logic [FC_W-1:0]     fl_cnt;
  logic [WB_DEPTH-1:0] slot_v;
  logic [4:0]          slot_rd [WB_DEPTH];
  logic [WB_DEPTH-1:0] match_a, match_b;
  logic                use_a, use_b, haz_a, haz_b, hazard, in_run;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      match_a[i] = slot_v[i] && (slot_rd[i] == dec_rs1);
      match_b[i] = slot_v[i] && (slot_rd[i] == dec_rs2);
    end
  end

  assign use_a = (dec_rs1 != 5'd0);
  assign use_b = dec_use_rs2 && (dec_rs2 != 5'd0);

`ifdef DECODE_FWD_EN
  localparam logic [WB_DEPTH-1:0] OLD_MASK = WB_DEPTH'(1) << (WB_DEPTH - 1);
  logic young_a, young_b;

  // Only a match confined to the retiring slot can be bypassed.
  assign young_a = |(match_a & ~OLD_MASK);
  assign young_b = |(match_b & ~OLD_MASK);
  assign haz_a   = use_a && young_a;
  assign haz_b   = use_b && young_b;
  assign fwd_a   = dec_ready && use_a && !young_a && match_a[WB_DEPTH-1];
  assign fwd_b   = dec_ready && use_b && !young_b && match_b[WB_DEPTH-1];
`else
  assign haz_a = use_a && (|match_a);
  assign haz_b = use_b && (|match_b);
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign hazard = haz_a || haz_b;

  // FSM: state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_RUN:   state_nxt = ST_RUN;
        ST_FLUSH: if (fl_cnt == '0) state_nxt = ST_RUN;
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_run    = (state == ST_RUN);
    dec_ready = nrst && dec_valid && in_run && ex_ready && !hazard && !flush;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fl_cnt <= '0;
    end else if (flush) begin
      fl_cnt <= FC_W'(FLUSH_CYC - 1);
    end else if (state == ST_FLUSH && fl_cnt != '0) begin
      fl_cnt <= fl_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot_v <= '0;
      for (int i = 0; i < WB_DEPTH; i++) slot_rd[i] <= 5'd0;
    end else if (flush) begin
      slot_v <= '0;
    end else if (ex_ready) begin
      for (int i = WB_DEPTH - 1; i > 0; i--) begin
        slot_v[i]  <= slot_v[i-1];
        slot_rd[i] <= slot_rd[i-1];
      end
      slot_v[0]  <= dec_ready && dec_we && (dec_rd != 5'd0);
      slot_rd[0] <= dec_rd;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      iss_valid <= 1'b0;
      iss_rd    <= 5'd0;
      iss_we    <= 1'b0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (ex_ready) begin
      iss_valid <= dec_ready;
      if (dec_ready) begin
        iss_rd <= dec_rd;
        iss_we <= dec_we;
      end
    end
  end

  // Hazard stalls counted even while execute is also back-pressuring.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= '0;
    end else if (in_run && dec_valid && hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_decode_hazard_ctrl;

  localparam int D  = 3;
  localparam int FC = 2;
  localparam int CW = 4;
`ifdef DECODE_FWD_EN
  localparam int   EXP_ST  = 2;
  localparam logic EXP_FWD = 1'b1;
`else
  localparam int   EXP_ST  = 3;
  localparam logic EXP_FWD = 1'b0;
`endif

  logic          clk = 1'b0, nrst = 1'b0;
  logic          dec_valid = 1'b0, dec_use_rs2 = 1'b0, dec_we = 1'b0;
  logic [4:0]    dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic          ex_ready = 1'b1, flush = 1'b0;
  logic          dec_ready, iss_valid, iss_we, fwd_a, fwd_b;
  logic [4:0]    iss_rd;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.WB_DEPTH(D), .FLUSH_CYC(FC), .CNT_W(CW)) dut (
    .clk(clk), .nrst(nrst), .dec_valid(dec_valid), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_we(dec_we), .ex_ready(ex_ready), .flush(flush),
    .dec_ready(dec_ready), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_we(iss_we), .stall_cnt(stall_cnt), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  int n_chk = 0, n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: queue of pending destinations (youngest first, -1 = none).
  int         mq[$];
  int         m_fl, m_st;
  logic       m_iv, m_we;
  logic [4:0] m_rd;
  logic       u_h, u_fa, u_fb, u_r;
  logic       c_h, c_fa, c_fb, c_r;

  function automatic void model_eval(output logic haz, output logic fa,
                                     output logic fb, output logic rdy);
    int ia = -1, ib = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (ia < 0 && dec_rs1 != 0 && mq[i] == int'(dec_rs1)) ia = i;
      if (ib < 0 && dec_use_rs2 && dec_rs2 != 0 && mq[i] == int'(dec_rs2)) ib = i;
    end
    fa = 1'b0;
    fb = 1'b0;
`ifdef DECODE_FWD_EN
    if (ia == D - 1) begin ia = -1; fa = 1'b1; end
    if (ib == D - 1) begin ib = -1; fb = 1'b1; end
`endif
    haz = (ia >= 0) || (ib >= 0);
    rdy = nrst && dec_valid && (m_fl == 0) && ex_ready && !haz && !flush;
    fa  = fa && rdy;
    fb  = fb && rdy;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mq = {};
      for (int i = 0; i < D; i++) mq.push_back(-1);
      m_fl = 0; m_st = 0; m_iv = 1'b0; m_rd = '0; m_we = 1'b0;
    end else begin
      model_eval(u_h, u_fa, u_fb, u_r);
      if (m_fl == 0 && dec_valid && u_h && m_st < (1 << CW) - 1) m_st++;
      if (flush) begin
        foreach (mq[i]) mq[i] = -1;
        m_iv = 1'b0;
        m_fl = FC;
      end else begin
        if (m_fl > 0) m_fl--;
        if (ex_ready) begin
          mq.push_front((u_r && dec_we && dec_rd != 0) ? int'(dec_rd) : -1);
          void'(mq.pop_back());
          m_iv = u_r;
          if (u_r) begin m_rd = dec_rd; m_we = dec_we; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_dec_ready", dec_ready, 0);
      chk("rst_iss_valid", iss_valid, 0);
      chk("rst_iss_rd", iss_rd, 0);
      chk("rst_iss_we", iss_we, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_fwd", {fwd_a, fwd_b}, 0);
    end else begin
      model_eval(c_h, c_fa, c_fb, c_r);
      chk("dec_ready", dec_ready, c_r);
      chk("iss_valid", iss_valid, m_iv);
      if (m_iv) begin
        chk("iss_rd", iss_rd, m_rd);
        chk("iss_we", iss_we, m_we);
      end
      chk("stall_cnt", stall_cnt, m_st);
      if (c_r) begin
        chk("fwd_a", fwd_a, c_fa);
        chk("fwd_b", fwd_b, c_fb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic use2, input logic [4:0] rd, input logic we);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2;
    dec_use_rs2 = use2; dec_rd = rd; dec_we = we;
  endtask

  task automatic drain();
    set_dec(0, 0, 0, 0, 0, 0);
    repeat (4) step();
  endtask

  int         stalls;
  logic       got;
  logic [CW-1:0] sc;

  initial begin
    repeat (3) step();
    nrst = 1'b1;
    step();

    // Back-to-back RAW on rd=5
    set_dec(1, 0, 0, 0, 5, 1);
    @(negedge clk); chk("raw_producer_ready", dec_ready, 1);
    step();
    set_dec(1, 5, 0, 0, 6, 1);
    stalls = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (dec_ready) got = 1'b1;
      else begin stalls++; step(); end
    end
    chk("raw_issued", got, 1);
    chk("raw_stall_cycles", stalls, EXP_ST);
    chk("raw_stall_cnt", stall_cnt, EXP_ST);
    chk("raw_fwd_a", fwd_a, EXP_FWD);
    step();
    drain();

    // x0 and we=0 never create hazards
    set_dec(1, 0, 0, 0, 0, 1); step();
    set_dec(1, 0, 0, 0, 0, 1);
    @(negedge clk); chk("x0_no_stall", dec_ready, 1);
    step();
    set_dec(1, 0, 0, 0, 7, 0); step();
    set_dec(1, 0, 7, 1, 0, 0);
    @(negedge clk); chk("no_we_no_stall", dec_ready, 1);
    step();
    drain();

    // rs2 only matters when used
    set_dec(1, 0, 0, 0, 9, 1); step();
    set_dec(1, 0, 9, 0, 0, 0);
    @(negedge clk); chk("rs2_unused_ready", dec_ready, 1);
    step();
    set_dec(1, 0, 9, 1, 0, 0);
    @(negedge clk); chk("rs2_used_stall", dec_ready, 0);
    step();
    drain();

    // Flush with three valid slots and an issuable instruction
    for (int i = 0; i < 3; i++) begin
      set_dec(1, 0, 0, 0, 5'(10 + i), 1);
      step();
    end
    set_dec(1, 0, 0, 0, 13, 1);
    flush = 1'b1;
    @(negedge clk); chk("flush_beats_issue", dec_ready, 0);
    step();
    flush = 1'b0;
    set_dec(1, 12, 0, 0, 0, 0);
    @(negedge clk); chk("flush_block1", dec_ready, 0); chk("flush_iss_clear", iss_valid, 0);
    step();
    @(negedge clk); chk("flush_block2", dec_ready, 0);
    step();
    @(negedge clk); chk("post_flush_issue", dec_ready, 1);
    step();
    drain();

    // Back-pressure holds slots and issue register
    set_dec(1, 0, 0, 0, 14, 1); step();
    set_dec(0, 0, 0, 0, 0, 0);
    ex_ready = 1'b0;
    sc = stall_cnt;
    repeat (4) begin
      @(negedge clk);
      chk("bp_iss_valid", iss_valid, 1);
      chk("bp_iss_rd", iss_rd, 14);
      chk("bp_stall_cnt", stall_cnt, sc);
      step();
    end
    ex_ready = 1'b1;
    set_dec(1, 14, 0, 0, 0, 0);
    @(negedge clk); chk("bp_slot_held", dec_ready, 0);
    step();
    drain();

    // Stall counter saturation (hazard held under back-pressure)
    set_dec(1, 0, 0, 0, 15, 1); step();
    set_dec(1, 15, 0, 0, 0, 0);
    ex_ready = 1'b0;
    repeat (20) step();
    @(negedge clk); chk("stall_saturate", stall_cnt, 15);
    step();
    ex_ready = 1'b1;
    drain();

    // Reset in the middle of a stall with two slots valid
    set_dec(1, 0, 0, 0, 3, 1); step();
    set_dec(1, 0, 0, 0, 4, 1); step();
    set_dec(1, 3, 0, 0, 0, 0);
    @(negedge clk); chk("pre_reset_stall", dec_ready, 0);
    step();
    nrst = 1'b0;
    @(negedge clk); chk("reset_stall_cnt", stall_cnt, 0); chk("reset_iss_valid", iss_valid, 0);
    step();
    nrst = 1'b1;
    @(negedge clk); chk("post_reset_no_stall", dec_ready, 1);
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
